// File: rtl/noc_arb_pkg.sv
// Shared types and helpers for the NoC priority arbiter.
//
// Contents:
//   arb_mode_t  - arbitration mode encoding. Code 3 is treated as round-robin by the arbiter.
//   arb_state_t - packet-lock FSM states.
//   clog2_min1  - $clog2 that never returns 0, so that id fields stay at least one bit wide.
package noc_arb_pkg;

    typedef enum logic [1:0] {
        ARB_FIXED = 2'd0,
        ARB_RR    = 2'd1,
        ARB_AGE   = 2'd2
    } arb_mode_t;

    typedef enum logic {
        ARB_IDLE   = 1'b0,
        ARB_LOCKED = 1'b1
    } arb_state_t;

    function automatic int unsigned clog2_min1(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/arb_rr_pick.sv
// Round-robin pick: a masked priority encoder with wrap-around.
//
// Returns the first set bit of req strictly after index start, wrapping from N-1 back to 0.
// The start index itself is considered last.
//
// Ports:
//   req      in  N   request vector
//   start    in  IW  index of the previous grant
//   grant_id out IW  selected index (0 when req is empty)
//   any      out 1   at least one request present
module arb_rr_pick #(
    parameter int unsigned N = 4,
    localparam int unsigned IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] start,
    output logic [IW-1:0] grant_id,
    output logic          any
);

    // Scan from the farthest offset down to the nearest, so the nearest hit overwrites the others.
    always_comb begin
        grant_id = '0;
        for (int off = N; off >= 1; off--) begin
            int idx;
            idx = (int'(start) + off) % N;
            if (req[IW'(idx)]) begin
                grant_id = IW'(idx);
            end
        end
    end

    assign any = |req;

endmodule

// File: rtl/noc_priority_arbiter.sv
// N-channel packet arbiter that merges per-node beat streams into one registered output stage.
//
// The arbitration mode is fixed-priority, round-robin or aged-priority, and it is selected at
// each packet decision. The winner owns the output until it sends its last beat. Per-channel
// age counters count lost arbitrations. In aged mode, a channel whose age has saturated is
// promoted above every static priority.
//
// Ports:
//   clk, res       clock (rising edge) and asynchronous active-high reset
//   mode           0 fixed, 1 round-robin, 2 aged, 3 round-robin
//   req_valid      per-channel beat valid
//   req_data       per-channel payload, channel i at [i*DATA_W +: DATA_W]
//   req_last       per-channel last-beat marker
//   req_prio       per-channel static priority, channel i at [i*PRIO_W +: PRIO_W]
//   req_ready      per-channel accept (only the owner, only while LOCKED)
//   out_valid/out_data/out_last/out_id  registered output beat, tagged with its source channel
//   out_ready      downstream accept
//   starve_flag    channel age has reached AGE_MAX
module noc_priority_arbiter
    import noc_arb_pkg::*;
#(
    parameter int unsigned NUM_CH  = 16,
    parameter int unsigned DATA_W  = 32,
    parameter int unsigned PRIO_W  = 2,
    parameter int unsigned AGE_MAX = 15,
    localparam int unsigned CH_W   = clog2_min1(NUM_CH),
    localparam int unsigned AGE_W  = $clog2(AGE_MAX + 1)
) (
    input  logic                     clk,
    input  logic                     res,
    input  logic [1:0]               mode,
    input  logic [NUM_CH-1:0]        req_valid,
    input  logic [NUM_CH*DATA_W-1:0] req_data,
    input  logic [NUM_CH-1:0]        req_last,
    input  logic [NUM_CH*PRIO_W-1:0] req_prio,
    output logic [NUM_CH-1:0]        req_ready,
    output logic                     out_valid,
    output logic [DATA_W-1:0]        out_data,
    output logic                     out_last,
    output logic [CH_W-1:0]          out_id,
    input  logic                     out_ready,
    output logic [NUM_CH-1:0]        starve_flag
);

    localparam int unsigned EP_W = PRIO_W + 1;

    arb_state_t      state_q, state_d;
    logic [CH_W-1:0] owner_q, owner_d;
    logic [CH_W-1:0] last_grant_q, last_grant_d;
    logic [AGE_W-1:0] age_q [NUM_CH];

    logic             out_valid_q, out_last_q;
    logic [DATA_W-1:0] out_data_q;
    logic [CH_W-1:0]  out_id_q;

    // ---------------------------------------------------------------------------------------
    // Aged-priority candidate set: valid channels at the highest effective priority.
    // ---------------------------------------------------------------------------------------
    logic [EP_W-1:0]   eff_prio [NUM_CH];
    logic [EP_W-1:0]   max_prio;
    logic [NUM_CH-1:0] top_req;

    always_comb begin
        max_prio = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (starve_flag[i]) begin
                eff_prio[i] = {1'b1, {PRIO_W{1'b0}}};
            end else begin
                eff_prio[i] = {1'b0, req_prio[i*PRIO_W +: PRIO_W]};
            end
            if (req_valid[i] && (eff_prio[i] > max_prio)) begin
                max_prio = eff_prio[i];
            end
        end
        for (int i = 0; i < NUM_CH; i++) begin
            top_req[i] = req_valid[i] && (eff_prio[i] == max_prio);
        end
    end

    // ---------------------------------------------------------------------------------------
    // Pickers. Fixed priority is round-robin starting after the top index, which yields the
    // lowest set index.
    // ---------------------------------------------------------------------------------------
    logic [CH_W-1:0] fix_id, rr_id, age_id, win_id;
    logic            fix_any, rr_any, age_any, win_any;

    arb_rr_pick #(.N(NUM_CH)) u_pick_fixed (
        .req      (req_valid),
        .start    (CH_W'(NUM_CH - 1)),
        .grant_id (fix_id),
        .any      (fix_any)
    );

    arb_rr_pick #(.N(NUM_CH)) u_pick_rr (
        .req      (req_valid),
        .start    (last_grant_q),
        .grant_id (rr_id),
        .any      (rr_any)
    );

    arb_rr_pick #(.N(NUM_CH)) u_pick_age (
        .req      (top_req),
        .start    (last_grant_q),
        .grant_id (age_id),
        .any      (age_any)
    );

    always_comb begin
        case (arb_mode_t'(mode))
            ARB_FIXED: begin
                win_id  = fix_id;
                win_any = fix_any;
            end
            ARB_AGE: begin
                win_id  = age_id;
                win_any = age_any;
            end
            default: begin
                win_id  = rr_id;
                win_any = rr_any;
            end
        endcase
    end

    // ---------------------------------------------------------------------------------------
    // Owner beat select and handshake.
    // ---------------------------------------------------------------------------------------
    logic              can_load, accept, grant_event;
    logic              sel_valid, sel_last;
    logic [DATA_W-1:0] sel_data;

    always_comb begin
        sel_valid = 1'b0;
        sel_last  = 1'b0;
        sel_data  = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (owner_q == CH_W'(i)) begin
                sel_valid = req_valid[i];
                sel_last  = req_last[i];
                sel_data  = req_data[i*DATA_W +: DATA_W];
            end
        end
    end

    assign can_load    = !out_valid_q || out_ready;
    assign accept      = (state_q == ARB_LOCKED) && sel_valid && can_load;
    assign grant_event = (state_q == ARB_IDLE) && win_any;

    // ---------------------------------------------------------------------------------------
    // FSM: state register, next-state logic, output logic.
    // ---------------------------------------------------------------------------------------
    always_ff @(posedge clk or posedge res) begin
        if (res) begin
            state_q      <= ARB_IDLE;
            owner_q      <= '0;
            last_grant_q <= CH_W'(NUM_CH - 1);
        end else begin
            state_q      <= state_d;
            owner_q      <= owner_d;
            last_grant_q <= last_grant_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        owner_d      = owner_q;
        last_grant_d = last_grant_q;
        unique case (state_q)
            ARB_IDLE: begin
                if (win_any) begin
                    state_d      = ARB_LOCKED;
                    owner_d      = win_id;
                    last_grant_d = win_id;
                end
            end
            ARB_LOCKED: begin
                // An owner that drops valid mid-packet simply keeps the lock.
                if (accept && sel_last) begin
                    state_d = ARB_IDLE;
                end
            end
            default: state_d = ARB_IDLE;
        endcase
    end

    always_comb begin
        req_ready = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            req_ready[i] = (state_q == ARB_LOCKED) && (owner_q == CH_W'(i)) && can_load;
        end
    end

    // ---------------------------------------------------------------------------------------
    // Output register. A reload wins over a drain in the same cycle.
    // ---------------------------------------------------------------------------------------
    always_ff @(posedge clk or posedge res) begin
        if (res) begin
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_last_q  <= 1'b0;
            out_id_q    <= '0;
        end else if (accept) begin
            out_valid_q <= 1'b1;
            out_data_q  <= sel_data;
            out_last_q  <= sel_last;
            out_id_q    <= owner_q;
        end else if (out_ready) begin
            out_valid_q <= 1'b0;
        end
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_last  = out_last_q;
    assign out_id    = out_id_q;

    // ---------------------------------------------------------------------------------------
    // Age counters. An idle channel forgets its wait immediately. A waiting channel ages only
    // when it loses a decision.
    // ---------------------------------------------------------------------------------------
    always_ff @(posedge clk or posedge res) begin
        if (res) begin
            for (int i = 0; i < NUM_CH; i++) begin
                age_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NUM_CH; i++) begin
                if (!req_valid[i]) begin
                    age_q[i] <= '0;
                end else if (grant_event) begin
                    if (win_id == CH_W'(i)) begin
                        age_q[i] <= '0;
                    end else if (age_q[i] != AGE_W'(AGE_MAX)) begin
                        age_q[i] <= age_q[i] + 1'b1;
                    end
                end
            end
        end
    end

    always_comb begin
        for (int i = 0; i < NUM_CH; i++) begin
            starve_flag[i] = (age_q[i] == AGE_W'(AGE_MAX));
        end
    end

endmodule
